sid_wave_combiner: RTL and testbench

//  Multi-voice combined-waveform lookup engine for the SID voice datapath. Replaces
//  the fixed single-table ROM: one loadable table RAM holds all four combined-waveform

---
 rtl/sid_wave_pkg.sv | 45 ++++
 rtl/sid_wave_table_ram.sv | 40 ++++
 rtl/sid_wave_combiner.sv | 145 ++++++++++++++
 tb/tb_sid_wave_combiner.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_wave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sid_wave_pkg
// Description : Shared constants and helpers for the SID combined-waveform
//               lookup engine. Defines the table mode encoding and the decode
//               from oscillator waveform selects to a table mode.
// Revision    : 1.0 - initial release
// ============================================================================
package sid_wave_pkg;

    // Table selector: each mode owns one 2^ACC_W slice of the table RAM
    localparam logic [1:0] MODE_ST  = 2'd0;  // tri + saw
    localparam logic [1:0] MODE_PT  = 2'd1;  // pulse + tri
    localparam logic [1:0] MODE_PS  = 2'd2;  // pulse + saw
    localparam logic [1:0] MODE_PST = 2'd3;  // pulse + saw + tri

    // Decoded waveform selection: is_comb=0 means the result is forced to zero
    typedef struct packed {
        logic       is_comb;
        logic [1:0] mode;
    } wave_sel_t;

    // Map {pulse,saw,tri} to a combined-waveform table. Single waveforms and
    // the all-off case have no table and yield is_comb=0.
    function automatic wave_sel_t wave_to_mode(input logic [2:0] pst);
        wave_sel_t sel;
        sel.is_comb = 1'b1;
        sel.mode    = MODE_ST;
        case (pst)
            3'b011:  sel.mode = MODE_ST;
            3'b101:  sel.mode = MODE_PT;
            3'b110:  sel.mode = MODE_PS;
            3'b111:  sel.mode = MODE_PST;
            default: sel.is_comb = 1'b0;
        endcase
        return sel;
    endfunction

    // Every mode except tri+saw involves the pulse waveform
    function automatic logic mode_has_pulse(input logic [1:0] mode);
        return (mode != MODE_ST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sid_wave_table_ram.sv
`default_nettype none
// ============================================================================
// Module      : sid_wave_table_ram
// Description : Simple dual-port table RAM, one write port and one registered
//               read port with read-first behaviour. Contents are not reset so
//               the array maps onto block RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module sid_wave_table_ram #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Write and registered read; the read samples the array before the write lands
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/sid_wave_combiner.sv
`default_nettype none
// ============================================================================
// Module      : sid_wave_combiner
// Description : Multi-voice combined-waveform lookup engine. A round-robin
//               slot pointer grants one voice per cycle access to a shared,
//               run-time loadable table RAM. Results appear two cycles after
//               the grant, gated by the captured pulse comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module sid_wave_combiner
    import sid_wave_pkg::*;
#(
    parameter int VOICES = 3,
    parameter int ACC_W  = 12,
    parameter int OUT_W  = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [VOICES-1:0]       req_valid,
    input  logic [VOICES*ACC_W-1:0] req_acc,
    input  logic [VOICES*4-1:0]     req_wave,
    input  logic [VOICES-1:0]       req_pulse,
    output logic [VOICES-1:0]       req_ack,
    output logic [VOICES*OUT_W-1:0] out_data,
    output logic [VOICES-1:0]       out_valid,
    input  logic                    wr_en,
    input  logic [ACC_W+1:0]        wr_addr,
    input  logic [OUT_W-1:0]        wr_data
);

    localparam int PTR_W  = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int ADDR_W = ACC_W + 2;

    // Slot pointer
    logic [PTR_W-1:0] ptr_q, ptr_d;

    // Issue-cycle decode of the granted voice
    logic             issue;
    logic [ACC_W-1:0] cur_acc;
    logic [3:0]       cur_wave;
    logic             cur_pulse;
    wave_sel_t        cur_sel;
    logic             cur_kill;
    logic             rd_en;
    logic [ADDR_W-1:0] rd_addr;

    // Capture stage, aligned with the RAM read register
    logic             s1_valid_q;
    logic [PTR_W-1:0] s1_voice_q;
    logic             s1_kill_q;

    // Output stage
    logic [OUT_W-1:0]        ram_rd_data;
    logic [VOICES-1:0]       out_valid_q, out_valid_d;
    logic [VOICES*OUT_W-1:0] out_data_q,  out_data_d;

    // Select the granted voice's inputs and decide whether it issues this cycle
    always_comb begin
        cur_acc   = req_acc[ptr_q*ACC_W +: ACC_W];
        cur_wave  = req_wave[ptr_q*4 +: 4];
        cur_pulse = req_pulse[ptr_q];
        cur_sel   = wave_to_mode(cur_wave[2:0]);
        // Noise overrides any combination; pulse modes need the comparator high
        cur_kill  = cur_wave[3] || !cur_sel.is_comb ||
                    (mode_has_pulse(cur_sel.mode) && !cur_pulse);
        issue     = !reset && !wr_en && req_valid[ptr_q];
        req_ack   = issue ? (VOICES'(1) << ptr_q) : '0;
        // Zero lookups never touch the RAM
        rd_en     = issue && !cur_wave[3] && cur_sel.is_comb;
        rd_addr   = {cur_sel.mode, cur_acc};
    end

    // Next slot: table writes freeze the scheduler, otherwise step and wrap
    always_comb begin
        ptr_d = ptr_q;
        if (!wr_en) begin
            if (ptr_q == PTR_W'(VOICES - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + PTR_W'(1);
            end
        end
    end

    // Slot pointer register
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Capture the issued voice and its gating decision alongside the RAM read
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_voice_q <= '0;
            s1_kill_q  <= 1'b0;
        end else begin
            s1_valid_q <= issue;
            s1_voice_q <= ptr_q;
            s1_kill_q  <= cur_kill;
        end
    end

    sid_wave_table_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (OUT_W)
    ) u_table_ram (
        .clock     (clock),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (ram_rd_data)
    );

    // Steer the completed lookup into its voice's output slot
    always_comb begin
        out_valid_d = '0;
        out_data_d  = out_data_q;
        if (s1_valid_q) begin
            out_valid_d = VOICES'(1) << s1_voice_q;
            out_data_d[s1_voice_q*OUT_W +: OUT_W] = s1_kill_q ? '0 : ram_rd_data;
        end
    end

    // Output registers; reset drops any lookup still in the pipeline
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sid_wave_combiner.sv
`default_nettype none
// ============================================================================
// Module      : tb_sid_wave_combiner
// Description : Self-checking bench for sid_wave_combiner. A cycle-level
//               reference model (table array + result queue) checks acks and
//               outputs every cycle; directed vectors and sequences cover the
//               load, gating, scheduling, stall and reset corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sid_wave_combiner;

    localparam int V  = 3;
    localparam int AW = 12;
    localparam int OW = 8;

    logic            clock = 1'b0;
    logic            reset;
    logic [V-1:0]    req_valid;
    logic [V*AW-1:0] req_acc;
    logic [V*4-1:0]  req_wave;
    logic [V-1:0]    req_pulse;
    logic [V-1:0]    req_ack;
    logic [V*OW-1:0] out_data;
    logic [V-1:0]    out_valid;
    logic            wr_en;
    logic [AW+1:0]   wr_addr;
    logic [OW-1:0]   wr_data;

    int checks   = 0;
    int failures = 0;

    sid_wave_combiner #(.VOICES(V), .ACC_W(AW), .OUT_W(OW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_acc   (req_acc),
        .req_wave  (req_wave),
        .req_pulse (req_pulse),
        .req_ack   (req_ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clock = ~clock;

    function automatic void chk(input string name, input int idx,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s voice=%0d got=%h expected=%h t=%0t", name, idx, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Reference model: table contents, slot pointer, results in flight
    // ------------------------------------------------------------------
    typedef struct {
        int         v;
        logic [7:0] val;
    } res_t;

    logic [7:0]   ref_mem [0:16383];
    logic [7:0]   exp_data [V];
    logic [V-1:0] exp_valid;
    int           mptr;
    bit           model_on = 1'b0;
    res_t         pend [$];

    function automatic logic [7:0] ref_lookup(input logic [3:0] wave,
                                              input logic [11:0] acc,
                                              input logic pulse);
        int m;
        if (wave[3]) return 8'h00;
        case (wave[2:0])
            3'b011:  m = 0;
            3'b101:  m = 1;
            3'b110:  m = 2;
            3'b111:  m = 3;
            default: return 8'h00;
        endcase
        if (m != 0 && !pulse) return 8'h00;
        return ref_mem[m*4096 + int'(acc)];
    endfunction

    // Advance the model on each rising edge using the inputs of the ending cycle
    always @(posedge clock) begin
        res_t r;
        if (reset) begin
            model_on  = 1'b1;
            mptr      = 0;
            pend.delete();
            exp_valid = '0;
            for (int i = 0; i < V; i++) exp_data[i] = 8'h00;
        end else if (model_on) begin
            exp_valid = '0;
            while (pend.size() > 0) begin
                r = pend.pop_front();
                exp_data[r.v]  = r.val;
                exp_valid[r.v] = 1'b1;
            end
            if (wr_en) begin
                ref_mem[wr_addr] = wr_data;
            end else begin
                if (req_valid[mptr]) begin
                    r.v   = mptr;
                    r.val = ref_lookup(req_wave[mptr*4 +: 4], req_acc[mptr*AW +: AW],
                                       req_pulse[mptr]);
                    pend.push_back(r);
                end
                mptr = (mptr + 1) % V;
            end
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clock) begin
        logic [V-1:0] exp_ack;
        if (model_on) begin
            exp_ack = (!reset && !wr_en && req_valid[mptr]) ? V'(1 << mptr) : '0;
            chk("req_ack", -1, 32'(req_ack), 32'(exp_ack));
            chk("out_valid", -1, 32'(out_valid), 32'(exp_valid));
            for (int v = 0; v < V; v++)
                chk("out_data", v, 32'(out_data[v*OW +: OW]), 32'(exp_data[v]));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called just after a rising edge)
    // ------------------------------------------------------------------
    task automatic tbl_write(input logic [1:0] m, input logic [11:0] idx, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = {m, idx};
        wr_data = d;
        @(posedge clock); #1;
        wr_en   = 1'b0;
    endtask

    task automatic set_voice(input int v, input logic [3:0] wave,
                             input logic [11:0] acc, input logic pulse);
        req_wave[v*4 +: 4]   = wave;
        req_acc[v*AW +: AW]  = acc;
        req_pulse[v]         = pulse;
    endtask

    // Wait for the voice's ack; leaves the bench at the falling edge of the ack cycle
    task automatic wait_ack(input int v, output bit got);
        got = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (req_ack[v]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout voice=%0d got=none expected=ack", v);
        end
    endtask

    task automatic lookup(input int v, input logic [3:0] wave, input logic [11:0] acc,
                          input logic pulse, input logic [7:0] exp);
        bit got;
        set_voice(v, wave, acc, pulse);
        req_valid = V'(1 << v);
        wait_ack(v, got);
        @(posedge clock); #1;
        req_valid = '0;
        @(posedge clock);
        @(negedge clock);
        chk("vec_valid", v, 32'(out_valid[v]), 32'(1));
        chk("vec_data", v, 32'(out_data[v*OW +: OW]), 32'(exp));
        @(posedge clock); #1;
    endtask

    typedef struct {
        int          v;
        logic [3:0]  wave;
        logic [11:0] acc;
        logic        pulse;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit got;
        vecs[0] = '{0, 4'b0111, 12'hfff, 1'b1, 8'hff};  // pulse+saw+tri
        vecs[1] = '{1, 4'b0111, 12'hfff, 1'b0, 8'h00};  // pulse gated off
        vecs[2] = '{2, 4'b0010, 12'h000, 1'b1, 8'h00};  // saw alone: zero
        vecs[3] = '{0, 4'b1011, 12'hfff, 1'b1, 8'h00};  // noise: zero
        vecs[4] = '{1, 4'b0011, 12'h7ff, 1'b0, 8'h7f};  // tri+saw ignores pulse
        vecs[5] = '{2, 4'b0101, 12'h123, 1'b1, 8'h5c};  // pulse+tri
        vecs[6] = '{0, 4'b0110, 12'h456, 1'b1, 8'ha3};  // pulse+saw
        vecs[7] = '{1, 4'b0110, 12'h456, 1'b0, 8'h00};  // pulse+saw gated

        for (int i = 0; i < 16384; i++) ref_mem[i] = 8'h00;

        reset     = 1'b1;
        req_valid = '1;
        req_acc   = '0;
        req_wave  = '0;
        req_pulse = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;

        // Reset held three edges with every voice requesting
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("first_ack", -1, 32'(req_ack), 32'(3'b001));
        @(posedge clock); #1;
        req_valid = '0;
        repeat (3) @(posedge clock);
        #1;

        // Table load: random background plus the directed entries
        for (int m = 0; m < 4; m++)
            for (int i = 0; i < 16; i++)
                tbl_write(2'(m), 12'(i), 8'($urandom));
        tbl_write(2'd3, 12'hfff, 8'hff);
        tbl_write(2'd0, 12'h7ff, 8'h7f);
        tbl_write(2'd1, 12'h123, 8'h5c);
        tbl_write(2'd2, 12'h456, 8'ha3);

        // Directed single-voice vectors
        for (int i = 0; i < 8; i++)
            lookup(vecs[i].v, vecs[i].wave, vecs[i].acc, vecs[i].pulse, vecs[i].exp);

        // Round robin with all voices requesting, then a 4-cycle write stall
        set_voice(0, 4'b0011, 12'd1, 1'b1);
        set_voice(1, 4'b0101, 12'd2, 1'b1);
        set_voice(2, 4'b0111, 12'd3, 1'b1);
        req_valid = '1;
        repeat (7) @(posedge clock);
        #1;
        tbl_write(2'd0, 12'd1, 8'hc3);
        tbl_write(2'd1, 12'd2, 8'h3c);
        tbl_write(2'd3, 12'd3, 8'h99);
        tbl_write(2'd2, 12'd9, 8'h42);
        repeat (6) @(posedge clock);
        @(negedge clock);
        chk("stall_new0", 0, 32'(out_data[0 +: OW]), 32'(8'hc3));
        chk("stall_new1", 1, 32'(out_data[OW +: OW]), 32'(8'h3c));
        chk("stall_new2", 2, 32'(out_data[2*OW +: OW]), 32'(8'h99));
        @(posedge clock); #1;
        req_valid = '0;
        repeat (3) @(posedge clock);
        #1;

        // Read issued, same address written the next cycle: old data returned
        tbl_write(2'd0, 12'd5, 8'h11);
        set_voice(0, 4'b0011, 12'd5, 1'b1);
        req_valid = 3'b001;
        wait_ack(0, got);
        @(posedge clock); #1;
        req_valid = '0;
        wr_en     = 1'b1;
        wr_addr   = {2'd0, 12'd5};
        wr_data   = 8'h22;
        @(posedge clock); #1;
        wr_en     = 1'b0;
        @(negedge clock);
        chk("rdfirst_valid", 0, 32'(out_valid[0]), 32'(1));
        chk("rdfirst_data", 0, 32'(out_data[0 +: OW]), 32'(8'h11));
        @(posedge clock); #1;
        lookup(0, 4'b0011, 12'd5, 1'b0, 8'h22);

        // Reset one cycle after voice 1 is acked: the lookup must vanish
        set_voice(1, 4'b0111, 12'hfff, 1'b1);
        req_valid = 3'b010;
        wait_ack(1, got);
        @(posedge clock); #1;
        reset     = 1'b1;
        req_valid = '0;
        @(posedge clock); #1;
        reset     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("rst_flight_valid", 1, 32'(out_valid[1]), 32'(0));
        end
        chk("rst_flight_data", 1, 32'(out_data[OW +: OW]), 32'(0));
        @(posedge clock); #1;

        // Randomized traffic over the loaded index range
        for (int n = 0; n < 400; n++) begin
            wr_en     = ($urandom_range(0, 7) == 0);
            wr_addr   = {2'($urandom), 12'($urandom_range(0, 15))};
            wr_data   = 8'($urandom);
            req_valid = V'($urandom);
            for (int v = 0; v < V; v++)
                set_voice(v, 4'($urandom), 12'($urandom_range(0, 15)), 1'($urandom));
            @(posedge clock); #1;
        end
        wr_en     = 1'b0;
        req_valid = '0;
        repeat (4) @(posedge clock);
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
